branch_ctrl: RTL and testbench

Branch resolution controller for the ID stage of the five-stage pipeline. It evaluates BEQZ/BNEZ/J/JR against a full-width zero test of the source operand. It stalls IF/ID while that operand is still being produced by a load in EX. It issues a one-cycle PC redirect plus IF/ID flush for taken branches. Optional saturating performance counters track branch behaviour.

---
 rtl/branch_ctrl.sv | 143 ++++++++++++++
 tb/tb_branch_ctrl.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_ctrl.sv
// Branch resolution controller for the ID stage: BEQZ/BNEZ/J/JR with load-use stall and registered redirect/flush.
// Optional saturating statistics counters are enabled with the BRANCH_STATS_EN macro.
module branch_ctrl #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             br_valid,
  input  logic [0:1]       br_type,
  input  logic [0:WIDTH-1] br_target,
  input  logic [0:WIDTH-1] rs_val,
  input  logic             rs_pending,
  input  logic             pipe_hold,
  output logic             stall_if_id,
  output logic             redirect,
  output logic [0:WIDTH-1] redirect_pc,
  output logic             flush_if_id,
  output logic [0:CNT_W-1] br_count,
  output logic [0:CNT_W-1] taken_count,
  output logic [0:CNT_W-1] stall_cycles
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    TAKEN = 2'd2
  } state_t;

  localparam logic [1:0] BT_BEQZ = 2'b00;
  localparam logic [1:0] BT_BNEZ = 2'b01;
  localparam logic [1:0] BT_J    = 2'b10;
  localparam logic [1:0] BT_JR   = 2'b11;

  state_t state_q, state_d;

  logic             op_needed;
  logic             rs_zero;
  logic             cond_taken;
  logic [0:WIDTH-1] target;
  logic             resolve;
  logic             resolve_taken;
  logic             redirect_q;
  logic [0:WIDTH-1] redirect_pc_q;

  // The zero test spans every bit, including bit 0 (the MSB).
  assign op_needed = (br_type != BT_J);
  assign rs_zero   = (rs_val == '0);
  assign target    = (br_type == BT_JR) ? rs_val : br_target;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    cond_taken = 1'b1;
    unique case (br_type)
      BT_BEQZ: cond_taken = rs_zero;
      BT_BNEZ: cond_taken = !rs_zero;
      default: cond_taken = 1'b1;
    endcase
  end

  always_comb begin
    state_d       = state_q;
    stall_if_id   = 1'b0;
    resolve       = 1'b0;
    resolve_taken = 1'b0;
    if (!pipe_hold) begin
      unique case (state_q)
        IDLE: begin
          if (br_valid) begin
            if (op_needed && rs_pending) begin
              stall_if_id = 1'b1;
              state_d     = WAIT;
            end else begin
              resolve       = 1'b1;
              resolve_taken = cond_taken;
              state_d       = cond_taken ? TAKEN : IDLE;
            end
          end
        end
        WAIT: begin
          // ID is held here, so the branch fields are read live every cycle.
          if (!br_valid) begin
            state_d = IDLE;
          end else if (rs_pending) begin
            stall_if_id = 1'b1;
          end else begin
            resolve       = 1'b1;
            resolve_taken = cond_taken;
            state_d       = cond_taken ? TAKEN : IDLE;
          end
        end
        TAKEN: begin
          // ID holds a wrong-path instruction; br_valid is ignored.
          state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
    if (reset) begin
      state_q       <= IDLE;
      redirect_q    <= 1'b0;
      redirect_pc_q <= '0;
    end else begin
      state_q    <= state_d;
      redirect_q <= (state_d == TAKEN);
      if (resolve_taken) redirect_pc_q <= target;
    end
  end

  assign redirect    = redirect_q;
  assign flush_if_id = redirect_q;
  assign redirect_pc = redirect_pc_q;

`ifdef BRANCH_STATS_EN
  logic [0:CNT_W-1] br_count_q, taken_count_q, stall_cycles_q;

  // resolve/stall are already suppressed under pipe_hold, which freezes the counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      br_count_q     <= '0;
      taken_count_q  <= '0;
      stall_cycles_q <= '0;
    end else begin
      if (resolve && (br_count_q != '1))          br_count_q     <= br_count_q + 1'b1;
      if (resolve_taken && (taken_count_q != '1)) taken_count_q  <= taken_count_q + 1'b1;
      if (stall_if_id && (stall_cycles_q != '1))  stall_cycles_q <= stall_cycles_q + 1'b1;
    end
  end

  assign br_count     = br_count_q;
  assign taken_count  = taken_count_q;
  assign stall_cycles = stall_cycles_q;
`else
  assign br_count     = '0;
  assign taken_count  = '0;
  assign stall_cycles = '0;
`endif

endmodule

// File: tb/tb_branch_ctrl.sv
// Directed self-checking bench for branch_ctrl; counter expectations follow BRANCH_STATS_EN.
module tb_branch_ctrl;
  localparam int WIDTH = 32;
  localparam int CNT_W = 4;
`ifdef BRANCH_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             reset;
  logic             br_valid;
  logic [0:1]       br_type;
  logic [0:WIDTH-1] br_target;
  logic [0:WIDTH-1] rs_val;
  logic             rs_pending;
  logic             pipe_hold;
  logic             stall_if_id;
  logic             redirect;
  logic [0:WIDTH-1] redirect_pc;
  logic             flush_if_id;
  logic [0:CNT_W-1] br_count, taken_count, stall_cycles;

  int n_cmp  = 0;
  int n_fail = 0;

  branch_ctrl #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .br_valid(br_valid), .br_type(br_type),
    .br_target(br_target), .rs_val(rs_val), .rs_pending(rs_pending),
    .pipe_hold(pipe_hold), .stall_if_id(stall_if_id), .redirect(redirect),
    .redirect_pc(redirect_pc), .flush_if_id(flush_if_id), .br_count(br_count),
    .taken_count(taken_count), .stall_cycles(stall_cycles)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    br_valid   = 1'b0;
    br_type    = 2'b00;
    br_target  = '0;
    rs_val     = '0;
    rs_pending = 1'b0;
    pipe_hold  = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic check_counts(input string name, input int eb, input int et, input int es);
    int xb, xt, xs;
    xb = STATS ? eb : 0;
    xt = STATS ? et : 0;
    xs = STATS ? es : 0;
    n_cmp++;
    if (int'(br_count) !== xb || int'(taken_count) !== xt || int'(stall_cycles) !== xs) begin
      n_fail++;
      $display("FAIL %s counters: got br=%0d taken=%0d stall=%0d, required br=%0d taken=%0d stall=%0d",
               name, br_count, taken_count, stall_cycles, xb, xt, xs);
    end
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    n_cmp++;
    if ({stall_if_id, redirect, flush_if_id} !== 3'b000 || redirect_pc !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_outputs: got stall=%b redir=%b flush=%b pc=%h, required 0 0 0 00000000",
               stall_if_id, redirect, flush_if_id, redirect_pc);
    end
    check_counts("reset", 0, 0, 0);
  endtask

  task automatic test_beqz_taken();
    do_reset();
    br_valid = 1'b1; br_type = 2'b00; rs_val = '0; br_target = 32'h0000_0040;
    #1;
    n_cmp++;
    if (stall_if_id !== 1'b0) begin
      n_fail++; $display("FAIL beqz_stall: got %b required 0", stall_if_id);
    end
    tick();
    idle_inputs();
    n_cmp++;
    if (redirect !== 1'b1 || flush_if_id !== 1'b1 || redirect_pc !== 32'h0000_0040) begin
      n_fail++;
      $display("FAIL beqz_redirect: got redir=%b flush=%b pc=%h, required 1 1 00000040",
               redirect, flush_if_id, redirect_pc);
    end
    tick();
    n_cmp++;
    if (redirect !== 1'b0 || flush_if_id !== 1'b0) begin
      n_fail++; $display("FAIL beqz_strobe_end: got redir=%b flush=%b, required 0 0", redirect, flush_if_id);
    end
    check_counts("beqz", 1, 1, 0);
  endtask

  task automatic test_bnez();
    do_reset();
    br_valid = 1'b1; br_type = 2'b01; rs_val = 32'h8000_0000; br_target = 32'h0000_0abc;
    tick();
    idle_inputs();
    n_cmp++;
    if (redirect !== 1'b1 || redirect_pc !== 32'h0000_0abc) begin
      n_fail++; $display("FAIL bnez_msb: got redir=%b pc=%h, required 1 00000abc", redirect, redirect_pc);
    end
    tick();
    br_valid = 1'b1; br_type = 2'b01; rs_val = '0; br_target = 32'h0000_0100;
    #1;
    n_cmp++;
    if (stall_if_id !== 1'b0) begin
      n_fail++; $display("FAIL bnez_zero_stall: got %b required 0", stall_if_id);
    end
    tick();
    idle_inputs();
    n_cmp++;
    if (redirect !== 1'b0 || flush_if_id !== 1'b0 || redirect_pc !== 32'h0000_0abc) begin
      n_fail++;
      $display("FAIL bnez_not_taken: got redir=%b flush=%b pc=%h, required 0 0 00000abc",
               redirect, flush_if_id, redirect_pc);
    end
    check_counts("bnez", 2, 1, 0);
  endtask

  task automatic test_jr_load_use();
    int stalls;
    do_reset();
    stalls = 0;
    br_valid = 1'b1; br_type = 2'b11; rs_val = 32'hdead_beef; rs_pending = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      if (stall_if_id === 1'b1) stalls++;
      n_cmp++;
      if (redirect !== 1'b0) begin
        n_fail++; $display("FAIL jr_early_redirect: cycle %0d got %b required 0", i, redirect);
      end
      tick();
    end
    rs_pending = 1'b0; rs_val = 32'h0000_1000;
    #1;
    if (stall_if_id === 1'b1) stalls++;
    n_cmp++;
    if (stalls !== 3) begin
      n_fail++; $display("FAIL jr_stall_count: got %0d required 3", stalls);
    end
    tick();
    idle_inputs();
    n_cmp++;
    if (redirect !== 1'b1 || flush_if_id !== 1'b1 || redirect_pc !== 32'h0000_1000) begin
      n_fail++;
      $display("FAIL jr_redirect: got redir=%b flush=%b pc=%h, required 1 1 00001000",
               redirect, flush_if_id, redirect_pc);
    end
    check_counts("jr", 1, 1, 3);
  endtask

  task automatic test_pipe_hold();
    int highs;
    do_reset();
    highs = 0;
    br_valid = 1'b1; br_type = 2'b10; br_target = 32'h0000_2000; rs_pending = 1'b1;
    #1;
    n_cmp++;
    if (stall_if_id !== 1'b0) begin
      n_fail++; $display("FAIL j_no_wait: got stall=%b required 0", stall_if_id);
    end
    tick();
    br_type = 2'b00; br_target = 32'h0000_3000; pipe_hold = 1'b1;
    for (int i = 0; i < 2; i++) begin
      #1;
      if (redirect === 1'b1) highs++;
      n_cmp++;
      if (stall_if_id !== 1'b0 || redirect_pc !== 32'h0000_2000) begin
        n_fail++;
        $display("FAIL hold_frozen: cycle %0d got stall=%b pc=%h, required 0 00002000", i, stall_if_id, redirect_pc);
      end
      tick();
    end
    pipe_hold = 1'b0; br_valid = 1'b0;
    #1;
    if (redirect === 1'b1) highs++;
    tick();
    n_cmp++;
    if (highs !== 3 || redirect !== 1'b0) begin
      n_fail++; $display("FAIL hold_redirect: got high_cycles=%0d after=%b, required 3 0", highs, redirect);
    end
    check_counts("hold", 1, 1, 0);
  endtask

  task automatic test_reset_in_wait();
    do_reset();
    br_valid = 1'b1; br_type = 2'b11; rs_val = 32'h0000_0400; rs_pending = 1'b1;
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    idle_inputs();
    #1;
    n_cmp++;
    if (stall_if_id !== 1'b0 || redirect !== 1'b0 || flush_if_id !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_wait: got stall=%b redir=%b flush=%b, required 0 0 0", stall_if_id, redirect, flush_if_id);
    end
    check_counts("reset_wait", 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      n_cmp++;
      if (redirect !== 1'b0) begin
        n_fail++; $display("FAIL reset_wait_late: cycle %0d got redir=%b required 0", i, redirect);
      end
    end
  endtask

  task automatic test_squash();
    do_reset();
    br_valid = 1'b1; br_type = 2'b00; rs_val = '0; rs_pending = 1'b1;
    tick();
    br_valid = 1'b0;
    #1;
    n_cmp++;
    if (stall_if_id !== 1'b0) begin
      n_fail++; $display("FAIL squash_stall: got %b required 0", stall_if_id);
    end
    tick();
    rs_pending = 1'b0;
    tick();
    n_cmp++;
    if (redirect !== 1'b0) begin
      n_fail++; $display("FAIL squash_redirect: got %b required 0", redirect);
    end
    check_counts("squash", 0, 0, 1);
  endtask

  task automatic test_back_to_back();
    int redirects;
    do_reset();
    redirects = 0;
    br_valid = 1'b1; br_type = 2'b10; br_target = 32'h0000_0080;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (redirect === 1'b1) redirects++;
    end
    idle_inputs();
    n_cmp++;
    if (redirects !== 20) begin
      n_fail++; $display("FAIL b2b_redirects: got %0d required 20", redirects);
    end
    check_counts("saturate", 15, 15, 0);
  endtask

  initial begin
    reset = 1'b1;
    idle_inputs();
    test_reset();
    test_beqz_taken();
    test_bnez();
    test_jr_load_use();
    test_pipe_hold();
    test_reset_in_wait();
    test_squash();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
